// File: rtl/yapp_pkt_tx.sv
// YAPP packet transmitter: buffers a requested payload, then sends header, payload and parity.
// Optional feature macro YAPP_TX_BAD_PARITY_EN adds a per-packet inverted-parity request input.
module yapp_pkt_tx #(
  parameter int MAX_LEN    = 63,
  parameter int GAP_CYCLES = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [1:0] req_addr,
  input  logic [5:0] req_len,
  output logic       req_ready,
  input  logic [7:0] pl_data,
  input  logic       pl_valid,
  output logic       pl_ready,
  output logic [7:0] in_data,
  output logic       in_data_vld,
  input  logic       in_suspend,
  output logic       busy,
  output logic       pkt_done,
  output logic       len_err
`ifdef YAPP_TX_BAD_PARITY_EN
  ,
  input  logic       bad_parity
`endif
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    HDR  = 3'd2,
    DATA = 3'd3,
    PAR  = 3'd4,
    GAP  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [5:0]    idx_q, idx_d;
  logic [5:0]    len_q, len_d;
  logic [1:0]    addr_q, addr_d;
  logic [7:0]    parity_q, parity_d;
  logic [7:0]    in_data_q, in_data_d;
  logic          in_data_vld_q, in_data_vld_d;
  logic          len_err_q, len_err_d;
  logic          bad_q, bad_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          buf_we_s;
  logic          req_ok_s;
  logic          bad_req_s;
  logic [7:0]    buf_q [MAX_LEN];

  function automatic logic [7:0] par_out(input logic [7:0] p, input logic inv);
    return inv ? ~p : p;
  endfunction

`ifdef YAPP_TX_BAD_PARITY_EN
  assign bad_req_s = bad_parity;
`else
  assign bad_req_s = 1'b0;
`endif

  assign req_ok_s = (req_len != 6'd0) && (req_len <= 6'(MAX_LEN));

  // Next-state logic; output bytes are computed from the next state so they leave a flop.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    len_d     = len_q;
    addr_d    = addr_q;
    parity_d  = parity_q;
    bad_d     = bad_q;
    gap_d     = gap_q;
    len_err_d = 1'b0;
    buf_we_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ok_s) begin
          len_d    = req_len;
          addr_d   = req_addr;
          parity_d = {req_len, req_addr};
          bad_d    = bad_req_s;
          idx_d    = 6'd0;
          state_d  = FILL;
        end else begin
          len_err_d = req_valid;
        end
      end
      FILL: begin
        if (pl_valid) begin
          buf_we_s = 1'b1;
          parity_d = parity_q ^ pl_data;
          idx_d    = idx_q + 6'd1;
          state_d  = (idx_q == len_q - 6'd1) ? HDR : FILL;
        end else begin
          state_d = FILL;
        end
      end
      HDR: begin
        if (!in_suspend) begin
          idx_d   = 6'd0;
          state_d = DATA;
        end else begin
          state_d = HDR;
        end
      end
      DATA: begin
        if (!in_suspend) begin
          if (idx_q == len_q - 6'd1) begin
            state_d = PAR;
          end else begin
            idx_d = idx_q + 6'd1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PAR: begin
        if (!in_suspend) begin
          gap_d   = '0;
          state_d = GAP;
        end else begin
          state_d = PAR;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    in_data_d     = 8'h00;
    in_data_vld_d = 1'b0;
    case (state_d)
      HDR: begin
        in_data_d     = {len_d, addr_d};
        in_data_vld_d = 1'b1;
      end
      DATA: begin
        in_data_d     = buf_q[idx_d];
        in_data_vld_d = 1'b1;
      end
      PAR: begin
        in_data_d     = par_out(parity_d, bad_d);
        in_data_vld_d = 1'b1;
      end
      default: begin
        in_data_d     = 8'h00;
        in_data_vld_d = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      idx_q         <= 6'd0;
      len_q         <= 6'd0;
      addr_q        <= 2'd0;
      parity_q      <= 8'h00;
      bad_q         <= 1'b0;
      gap_q         <= '0;
      len_err_q     <= 1'b0;
      in_data_q     <= 8'h00;
      in_data_vld_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      addr_q        <= addr_d;
      parity_q      <= parity_d;
      bad_q         <= bad_d;
      gap_q         <= gap_d;
      len_err_q     <= len_err_d;
      in_data_q     <= in_data_d;
      in_data_vld_q <= in_data_vld_d;
    end
  end

  // Payload store; entries are always written before they are read, so no reset.
  always_ff @(posedge clock) begin
    if (buf_we_s) begin
      buf_q[idx_q] <= pl_data;
    end
  end

  assign in_data     = in_data_q;
  assign in_data_vld = in_data_vld_q;
  assign len_err     = len_err_q;
  assign req_ready   = (state_q == IDLE);
  assign pl_ready    = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  // The parity transfer is decided by this cycle's suspend, so the pulse cannot be registered.
  assign pkt_done    = (state_q == PAR) && !in_suspend;

endmodule

// File: tb/tb_yapp_pkt_tx.sv
// Self-checking bench for yapp_pkt_tx: a packet-level byte queue model checked every cycle,
// plus literal expectations for each directed packet.
module tb_yapp_pkt_tx;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_ready;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] in_data;
  logic       in_data_vld;
  logic       in_suspend;
  logic       busy;
  logic       pkt_done;
  logic       len_err;
`ifdef YAPP_TX_BAD_PARITY_EN
  logic       bad_parity;
`endif

  yapp_pkt_tx dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_len     (req_len),
    .req_ready   (req_ready),
    .pl_data     (pl_data),
    .pl_valid    (pl_valid),
    .pl_ready    (pl_ready),
    .in_data     (in_data),
    .in_data_vld (in_data_vld),
    .in_suspend  (in_suspend),
    .busy        (busy),
    .pkt_done    (pkt_done),
    .len_err     (len_err)
`ifdef YAPP_TX_BAD_PARITY_EN
    ,
    .bad_parity  (bad_parity)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs[$];
  logic [7:0] pay [64];
  int n_checks = 0;
  int n_fail = 0;
  int pk_idx = 0;
  int vld_cycles = 0;
  int gap_chk = 0;
  int susp_mode = 0;
  int hdr_s = 0;
  int dat_s = 0;
  bit in_pkt = 1'b0;
  bit filling = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected byte stream of one packet: header, payload, XOR of all of them (optionally inverted).
  task automatic model_push(input logic [1:0] a, input logic [5:0] l, input logic inv);
    logic [7:0] p;
    p = {l, a};
    exp_q.push_back('{b: p, last: 1'b0});
    for (int i = 0; i < int'(l); i++) begin
      exp_q.push_back('{b: pay[i], last: 1'b0});
      p = p ^ pay[i];
    end
    exp_q.push_back('{b: (inv ? ~p : p), last: 1'b1});
  endtask

  task automatic wait_req();
    int t;
    t = 0;
    while (!req_ready && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) chk("req_ready_timeout", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input int gaps, input logic inv);
    int t;
    model_push(a, l, inv);
    wait_req();
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = l;
`ifdef YAPP_TX_BAD_PARITY_EN
    bad_parity = inv;
`endif
    tick();
    req_valid = 1'b0;
    filling   = 1'b1;
    for (int i = 0; i < int'(l); i++) begin
      if (gaps > 0) begin
        pl_valid = 1'b0;
        repeat ($urandom_range(0, gaps)) tick();
      end
      pl_data  = pay[i];
      pl_valid = 1'b1;
      t = 0;
      while (!pl_ready && t < 100) begin
        tick();
        t++;
      end
      if (t >= 100) chk("pl_ready_timeout", {31'd0, pl_ready}, 32'd1);
      tick();
    end
    pl_valid = 1'b0;
    filling  = 1'b0;
    chk("hdr_latency_vld", {31'd0, in_data_vld}, 32'd1);
    chk("hdr_latency_data", {24'd0, in_data}, {24'd0, l, a});
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      tick();
      t++;
    end
    if (t >= 1000) chk("drain_timeout", exp_q.size(), 32'd0);
    tick();
    tick();
    tick();
  endtask

  task automatic new_test();
    exp_q.delete();
    obs.delete();
    vld_cycles = 0;
    in_pkt     = 1'b0;
    pk_idx     = 0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_pl_ready"}, {31'd0, pl_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_vld"}, {31'd0, in_data_vld}, 32'd0);
    chk({tag, "_data"}, {24'd0, in_data}, 32'd0);
    chk({tag, "_pkt_done"}, {31'd0, pkt_done}, 32'd0);
    chk({tag, "_len_err"}, {31'd0, len_err}, 32'd0);
  endtask

  // Per-cycle compare of the output stream against the model queue.
  always @(negedge clock) begin
    if (reset) begin
      if (gap_chk == 1) begin
        chk("gap_vld", {31'd0, in_data_vld}, 32'd0);
        chk("gap_data", {24'd0, in_data}, 32'd0);
        gap_chk = 2;
      end else if (gap_chk == 2) begin
        chk("ready_after_gap", {31'd0, req_ready}, 32'd1);
        gap_chk = 0;
      end
      if (filling) chk("vld_during_fill", {31'd0, in_data_vld}, 32'd0);
      if (in_data_vld) begin
        vld_cycles++;
        if (exp_q.size() == 0) begin
          chk("unexpected_vld", {31'd0, in_data_vld}, 32'd0);
        end else begin
          chk("data", {24'd0, in_data}, {24'd0, exp_q[0].b});
          if (!in_suspend) begin
            chk("pkt_done", {31'd0, pkt_done}, {31'd0, exp_q[0].last});
            obs.push_back(in_data);
            if (exp_q[0].last) begin
              in_pkt  = 1'b0;
              pk_idx  = 0;
              gap_chk = 1;
            end else begin
              in_pkt = 1'b1;
              pk_idx++;
            end
            void'(exp_q.pop_front());
          end else begin
            chk("pkt_done_suspended", {31'd0, pkt_done}, 32'd0);
          end
        end
      end else begin
        if (in_pkt) chk("vld_contiguous", {31'd0, in_data_vld}, 32'd1);
        chk("pkt_done_idle", {31'd0, pkt_done}, 32'd0);
      end
    end
  end

  // Backpressure driver: scripted header/byte-2 suspends, or toggling every cycle.
  initial begin
    in_suspend = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (susp_mode)
        1: begin
          if (in_data_vld && pk_idx == 0 && hdr_s < 3) begin
            in_suspend = 1'b1;
            hdr_s++;
          end else if (in_data_vld && pk_idx == 2 && dat_s < 2) begin
            in_suspend = 1'b1;
            dat_s++;
          end else begin
            in_suspend = 1'b0;
          end
        end
        2: in_suspend = ~in_suspend;
        default: in_suspend = 1'b0;
      endcase
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = 2'd0;
    req_len   = 6'd0;
    pl_data   = 8'h00;
    pl_valid  = 1'b0;
`ifdef YAPP_TX_BAD_PARITY_EN
    bad_parity = 1'b0;
`endif
    tick();
    tick();
    reset = 1'b1;
    chk_reset_state("reset");

    // Basic packet, no suspend.
    new_test();
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    send_pkt(2'd1, 6'd4, 0, 1'b0);
    wait_drain();
    chk("t1_count", obs.size(), 32'd6);
    chk("t1_hdr", {24'd0, obs[0]}, 32'h11);
    chk("t1_b0", {24'd0, obs[1]}, 32'h11);
    chk("t1_b3", {24'd0, obs[4]}, 32'h44);
    chk("t1_par", {24'd0, obs[5]}, 32'h55);
    chk("t1_vld_cycles", vld_cycles, 32'd6);

    // Same packet with suspends on the header and on payload byte 2.
    new_test();
    hdr_s = 0;
    dat_s = 0;
    susp_mode = 1;
    send_pkt(2'd1, 6'd4, 0, 1'b0);
    wait_drain();
    susp_mode = 0;
    chk("t2_count", obs.size(), 32'd6);
    chk("t2_hdr", {24'd0, obs[0]}, 32'h11);
    chk("t2_b1", {24'd0, obs[2]}, 32'h22);
    chk("t2_par", {24'd0, obs[5]}, 32'h55);
    chk("t2_vld_cycles", vld_cycles, 32'd11);

    // Illegal zero-length request, then a maximum-length packet.
    new_test();
    wait_req();
    req_valid = 1'b1;
    req_addr  = 2'd2;
    req_len   = 6'd0;
    tick();
    req_valid = 1'b0;
    chk("len_err_pulse", {31'd0, len_err}, 32'd1);
    chk("len_err_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("len_err_clear", {31'd0, len_err}, 32'd0);
    chk("len_err_no_vld", {31'd0, in_data_vld}, 32'd0);
    for (int i = 0; i < 63; i++) pay[i] = 8'(i);
    send_pkt(2'd2, 6'd63, 0, 1'b0);
    wait_drain();
    chk("t3_count", obs.size(), 32'd65);
    chk("t3_hdr", {24'd0, obs[0]}, 32'hFE);
    chk("t3_b10", {24'd0, obs[11]}, 32'h0A);
    chk("t3_b62", {24'd0, obs[63]}, 32'h3E);
    chk("t3_par", {24'd0, obs[64]}, 32'hC1);

    // Payload with random valid gaps; output under toggling suspend.
    new_test();
    for (int i = 0; i < 10; i++) pay[i] = 8'h30 + 8'(i * 7);
    susp_mode = 2;
    send_pkt(2'd3, 6'd10, 3, 1'b0);
    wait_drain();
    susp_mode = 0;
    chk("t4_count", obs.size(), 32'd12);
    chk("t4_hdr", {24'd0, obs[0]}, 32'h2B);
    for (int i = 0; i < 10; i++) chk("t4_payload", {24'd0, obs[i + 1]}, {24'd0, 8'h30 + 8'(i * 7)});

    // Reset in the middle of the payload, then a fresh short packet.
    new_test();
    for (int i = 0; i < 8; i++) pay[i] = 8'h80 + 8'(i);
    send_pkt(2'd0, 6'd8, 0, 1'b0);
    t = 0;
    while (pk_idx != 3 && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("mid_pkt_timeout", pk_idx, 32'd3);
    reset = 1'b0;
    exp_q.delete();
    in_pkt  = 1'b0;
    pk_idx  = 0;
    gap_chk = 0;
    tick();
    reset = 1'b1;
    chk_reset_state("midreset");
    tick();
    chk("midreset_no_vld", {31'd0, in_data_vld}, 32'd0);
    new_test();
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_pkt(2'd1, 6'd2, 0, 1'b0);
    wait_drain();
    chk("t5_count", obs.size(), 32'd4);
    chk("t5_hdr", {24'd0, obs[0]}, 32'h09);
    chk("t5_b1", {24'd0, obs[2]}, 32'hC3);
    chk("t5_par", {24'd0, obs[3]}, 32'h90);

`ifdef YAPP_TX_BAD_PARITY_EN
    new_test();
    pay[0] = 8'hA5;
    send_pkt(2'd0, 6'd1, 0, 1'b1);
    wait_drain();
    chk("t6_hdr", {24'd0, obs[0]}, 32'h04);
    chk("t6_data", {24'd0, obs[1]}, 32'hA5);
    chk("t6_bad_par", {24'd0, obs[2]}, 32'h5E);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/yapp_pkt_tx.md
Name: yapp_pkt_tx

Overview:
- Upstream YAPP packet source that drives the router's YAPP input port: `in_data`, `in_data_vld`, `in_suspend`.
- Accepts a packet request (address, length) and a payload byte stream, and buffers the whole payload.
- Then emits a contiguous YAPP packet: header, payload, parity. It honours `in_suspend` throughout.
- Sits between the host/stimulus side and the router input.

Parameters:
- MAX_LEN, 63: maximum payload length in bytes. Range 1..63; the 6-bit length field caps it.
- GAP_CYCLES, 1: minimum cycles with `in_data_vld` low after each packet. Must be at least 1.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- req_valid  input  1  packet request valid
- req_addr  input  2  destination channel, 0..3 (3 is passed through unchanged)
- req_len  input  6  payload length in bytes
- req_ready  output  1  request accepted when req_valid && req_ready
- pl_data  input  8  payload byte
- pl_valid  input  1  payload byte valid
- pl_ready  output  1  payload byte accepted when pl_valid && pl_ready
- in_data  output  8  YAPP byte to router
- in_data_vld  output  1  YAPP byte valid
- in_suspend  input  1  router backpressure
- busy  output  1  high in any state other than IDLE
- pkt_done  output  1  one-cycle pulse on the cycle the parity byte transfers
- len_err  output  1  one-cycle pulse when an illegal request is dropped

Behaviour:
- Reset (reset==0 at a rising edge), from any state, including mid-packet:
  - state goes to IDLE; in_data=8'h00; in_data_vld=0.
  - req_ready=1 on the first cycle after reset releases; pl_ready=0; busy=0; pkt_done=0; len_err=0.
  - Counters and parity are cleared; buffer contents are don't-care.
  - A packet in flight is abandoned with no parity byte.
- Transfer rule: a byte transfers on a rising edge where in_data_vld && !in_suspend. While in_suspend=1 and in_data_vld=1, in_data holds stable.
- IDLE:
  - req_ready=1.
  - On request accept with 1 <= req_len <= MAX_LEN: latch addr and len, set parity = {len,addr}, go to FILL.
  - If req_len==0 or req_len>MAX_LEN: pulse len_err the next cycle, stay in IDLE, emit no packet.
- FILL:
  - pl_ready=1 and req_ready=0.
  - Each accepted byte is written to buffer[idx], XORed into parity, and idx increments.
  - When the len-th byte is accepted, go to HDR on the next cycle.
  - pl_valid gaps are allowed here. in_data_vld stays 0.
- HDR: in_data_vld=1, in_data={len[5:0],addr[1:0]}. On transfer, idx=0 and go to DATA.
- DATA:
  - in_data=buffer[idx].
  - On transfer, idx increments; after the len-th byte, go to PAR.
  - in_data_vld is never deasserted between header and parity.
- PAR: in_data=parity, which is the XOR of the header and all payload bytes. On transfer, pulse pkt_done and go to GAP.
- GAP:
  - in_data_vld=0 and in_data=8'h00 for GAP_CYCLES cycles, then go to IDLE.
  - in_suspend is ignored in GAP, IDLE and FILL.
- Latency:
  - Last payload byte accepted at cycle F puts the header on in_data at F+1.
  - With no suspend, the packet occupies len+2 consecutive cycles.
  - req_ready reasserts GAP_CYCLES cycles after the parity transfer.
- Suspend asserted in the same cycle vld first rises: the byte is held; there is no loss or duplication.
- Suspend toggling every cycle: each byte transfers exactly once.
- Width rules: idx is 6 bits; parity is 8 bits; the buffer is MAX_LEN x 8.

Optional Feature:
- Macro: YAPP_TX_BAD_PARITY_EN.
- When defined:
  - Adds input port `bad_parity` (1 bit), sampled on request accept.
  - If it was 1, the PAR byte is driven as ~parity; everything else is unchanged.
- When undefined: the port is absent and parity is always correct.

Test Plan:
- Reset, then req addr=1 len=4 with payload 11,22,33,44 and no suspend:
  - in_data sequence is 8'h11, 11,22,33,44, parity 8'h55 on 6 consecutive cycles starting the cycle after the last payload accept.
  - pkt_done pulses with the parity byte.
  - vld is low for 1 cycle after parity.
- Same packet with in_suspend high for 3 cycles while the header is valid, and again for 2 cycles during byte 2:
  - in_data is held stable through each suspend.
  - The transferred sequence is identical; total vld-high cycles = 6+5 = 11.
- req len=0, then req len=63 addr=2 with payload 0..62:
  - First request gives a len_err pulse and no vld.
  - Second gives header 8'hFE, 63 bytes 0..62, then correct parity.
- pl_valid driven with random gaps during FILL for len=10:
  - No vld until all 10 are accepted.
  - The output packet is contiguous and matches the input.
- Reset driven low during DATA byte 3 of a len=8 packet:
  - Next cycle in_data_vld=0 with no parity and no pkt_done; req_ready=1 on the first cycle after reset releases.
  - A new len=2 packet then transmits correctly.
- With YAPP_TX_BAD_PARITY_EN defined, bad_parity=1 with addr=0 len=1 payload 8'hA5:
  - Header 8'h04, data 8'hA5, parity byte 8'h5E (~8'hA1).
